mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit of the five-stage MIPS core. It takes the EX/MEM-latched ALU result as the effective address and the rt value as store data. It drives the SRAM-like data-side bus (req/addr_ok/data_ok) that the AXI bridge converts, and returns aligned, extended load data to writeback. It detects address-error exceptions and stalls the pipeline until the access completes.

## Interface
- No parameters. Op encodings are the `EXE_LB_OP, LBU, LH, LHU, LW, SB, SH, SW` codes from defines.vh.
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- op  in  8  memory op of the instruction in M; any non-load/store code means no access
- addr  in  32  effective address (ALU y[31:0])
- wdata  in  32  store source (rt)
- flush  in  1  exception/flush of M stage
- stall_m  in  1  M held by hazard unit for reasons other than this block
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  request address (unmodified addr)
- data_wdata  out  32  replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response/read data valid
- data_rdata  in  32  read data
- rdata_out  out  32  extended load result
- lsu_stall  out  1  stall request to hazard unit
- adel  out  1  load address error
- ades  out  1  store address error
- badvaddr  out  32  faulting address

## Operation
- Alignment: half ops need addr[0]=0; word ops need addr[1:0]=0. A violation sets adel (loads) or ades (stores) combinationally and sets badvaddr=addr. No request is issued.
- Store data: SB -> {4{wdata[7:0]}}; SH -> {2{wdata[15:0]}}; SW -> wdata. data_wdata = 0 for loads.
- Load extract (little-endian), using addr[1:0] latched at request:
  - LB/LBU: byte addr[1:0], sign/zero-extended.
  - LH/LHU: half addr[1], sign/zero-extended.
  - LW: whole word.
- FSM states: IDLE, WAIT_ADDR, WAIT_DATA, CANCEL, DONE.
  - IDLE: a valid access (load/store op, no error, no flush) asserts data_req. On addr_ok go WAIT_DATA, else WAIT_ADDR.
  - WAIT_ADDR: data_req held with stable addr/size/wr/wdata until addr_ok, then WAIT_DATA. A flush here does not drop req; on addr_ok go CANCEL.
  - WAIT_DATA: on data_ok, latch extracted rdata and go DONE. A flush seen here goes CANCEL.
  - CANCEL: wait for data_ok, discard it, go IDLE.
  - DONE: hold rdata_out. Return to IDLE when stall_m=0.
- Request fields (addr, size, wr, wdata, op) are registered at issue. The bus sees stable values while req is high.
- Only one outstanding transaction at a time.

## Timing
- Reset: state IDLE, data_req 0, data_wr 0, data_size 0, data_addr 0, data_wdata 0, rdata_out 0, lsu_stall 0. adel, ades and badvaddr are 0 while op is a non-memory code.
- Reset mid-transaction returns the block to IDLE immediately. The bridge is reset by the same rst, so no stale data_ok is expected.
- lsu_stall is combinational. It is 1 in these cases:
  - IDLE with a valid access;
  - WAIT_ADDR;
  - WAIT_DATA;
  - CANCEL.
  - It is 0 in DONE and for faulting or no-access ops.
- Minimum latency: addr_ok in the issue cycle and data_ok on the next cycle. This gives 2 stall cycles, with rdata_out valid in the third cycle (DONE).
- data_ok in the same cycle as addr_ok is not legal from the bridge and is ignored.
- Stores complete on data_ok like loads; rdata_out is unchanged by stores.
- Once in DONE with stall_m=1, no re-issue occurs however long the stall lasts.

## Test plan
- LW addr=0x1000, rdata=0xDEADBEEF, addr_ok in cycle 0, data_ok in cycle 1 -> lsu_stall=1 for 2 cycles, then rdata_out=0xDEADBEEF and exactly one req.
- LB addr=0x1003 with rdata=0x80FF_0000, and LBU at the same address -> 0xFFFFFF80 and 0x00000080. LH/LHU at 0x1002 -> 0xFFFF80FF and 0x000080FF.
- SH addr=0x2002, wdata=0x1234ABCD -> data_wr=1, size=1, data_wdata=0xABCDABCD. SB -> 0xCDCDCDCD.
- LW addr=0x1001 -> adel=1, badvaddr=0x1001, no req, lsu_stall=0. SH at 0x2001 -> ades=1.
- addr_ok delayed 3 cycles -> req and all fields stable for 4 cycles. flush asserted in WAIT_DATA -> block waits for data_ok, rdata_out is not updated, then IDLE.
- Completion with stall_m=1 for 5 cycles -> block stays in DONE, no second req, rdata_out held. rst during WAIT_DATA -> next cycle IDLE with all outputs at reset values.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one SRAM-like data-bus transaction per
// load/store, checks alignment, and returns aligned, extended load data.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  input  logic        stall_m,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] rdata_out,
  output logic        lsu_stall,
  output logic        adel,
  output logic        ades,
  output logic [31:0] badvaddr
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ADDR,
    S_WAIT_DATA,
    S_CANCEL,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cancel_q, cancel_d;

  logic        is_load, is_store;
  logic [1:0]  size_dec;
  logic        misaligned;
  logic        valid_access;
  logic [31:0] wdata_dec;

  // Decode of the op currently sitting in M.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    size_dec  = 2'd0;
    wdata_dec = 32'h0;
    case (op)
      OP_LB, OP_LBU: begin
        is_load  = 1'b1;
        size_dec = 2'd0;
      end
      OP_LH, OP_LHU: begin
        is_load  = 1'b1;
        size_dec = 2'd1;
      end
      OP_LW: begin
        is_load  = 1'b1;
        size_dec = 2'd2;
      end
      OP_SB: begin
        is_store  = 1'b1;
        size_dec  = 2'd0;
        wdata_dec = {4{wdata[7:0]}};
      end
      OP_SH: begin
        is_store  = 1'b1;
        size_dec  = 2'd1;
        wdata_dec = {2{wdata[15:0]}};
      end
      OP_SW: begin
        is_store  = 1'b1;
        size_dec  = 2'd2;
        wdata_dec = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (size_dec == 2'd1) begin
      misaligned = addr[0];
    end else if (size_dec == 2'd2) begin
      misaligned = |addr[1:0];
    end
  end

  assign adel         = is_load & misaligned;
  assign ades         = is_store & misaligned;
  assign badvaddr     = (adel | ades) ? addr : 32'h0;
  assign valid_access = (is_load | is_store) & ~misaligned & ~flush;

  // Little-endian extraction uses the offset latched at issue, not the live addr.
  logic [31:0] rdata_shift;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;

  always_comb begin
    rdata_shift = data_rdata >> {addr_q[1:0], 3'b000};
    byte_v      = rdata_shift[7:0];
    half_v      = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_q)
      OP_LB:   load_ext = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  load_ext = {24'h0, byte_v};
      OP_LH:   load_ext = {{16{half_v[15]}}, half_v};
      OP_LHU:  load_ext = {16'h0, half_v};
      default: load_ext = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0;
      size_q   <= 2'd0;
      wr_q     <= 1'b0;
      wdata_q  <= 32'h0;
      op_q     <= 8'h0;
      rdata_q  <= 32'h0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      op_q     <= op_d;
      rdata_q  <= rdata_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    rdata_d    = rdata_q;
    cancel_d   = cancel_q;
    data_req   = 1'b0;
    data_wr    = wr_q;
    data_size  = size_q;
    data_addr  = addr_q;
    data_wdata = wdata_q;
    lsu_stall  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cancel_d   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        if (valid_access) begin
          // The issue cycle drives the bus straight from the decode so that
          // an immediate addr_ok costs no extra cycle.
          data_req   = 1'b1;
          data_wr    = is_store;
          data_size  = size_dec;
          data_addr  = addr;
          data_wdata = wdata_dec;
          lsu_stall  = 1'b1;
          addr_d     = addr;
          size_d     = size_dec;
          wr_d       = is_store;
          wdata_d    = wdata_dec;
          op_d       = op;
          state_d    = data_addr_ok ? S_WAIT_DATA : S_WAIT_ADDR;
        end
      end

      S_WAIT_ADDR: begin
        data_req  = 1'b1;
        lsu_stall = 1'b1;
        if (flush) begin
          cancel_d = 1'b1;
        end
        if (data_addr_ok) begin
          state_d = (cancel_q | flush) ? S_CANCEL : S_WAIT_DATA;
        end
      end

      S_WAIT_DATA: begin
        lsu_stall = 1'b1;
        if (data_data_ok) begin
          // A flush arriving with the response simply drops it.
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (!wr_q) begin
              rdata_d = load_ext;
            end
          end
        end else if (flush) begin
          state_d = S_CANCEL;
        end
      end

      S_CANCEL: begin
        lsu_stall = 1'b1;
        if (data_data_ok) begin
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        if (!stall_m) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table of single transactions
// followed by hand-written multi-cycle sequences.
module tb_mem_access_unit;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  op;
  logic [31:0] addr, wdata;
  logic        flush, stall_m;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] rdata_out;
  logic        lsu_stall, adel, ades;
  logic [31:0] badvaddr;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int req_cycles = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .addr        (addr),
    .wdata       (wdata),
    .flush       (flush),
    .stall_m     (stall_m),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .rdata_out   (rdata_out),
    .lsu_stall   (lsu_stall),
    .adel        (adel),
    .ades        (ades),
    .badvaddr    (badvaddr)
  );

  always @(posedge clk) begin
    if (data_req) req_cycles <= req_cycles + 1;
    if (data_req && data_addr_ok) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, data_req, 0);
    chk({tag, "_wr"}, data_wr, 0);
    chk({tag, "_size"}, data_size, 0);
    chk({tag, "_addr"}, data_addr, 0);
    chk({tag, "_wdata"}, data_wdata, 0);
    chk({tag, "_rdata_out"}, rdata_out, 0);
    chk({tag, "_stall"}, lsu_stall, 0);
    chk({tag, "_adel"}, adel, 0);
    chk({tag, "_ades"}, ades, 0);
    chk({tag, "_badvaddr"}, badvaddr, 0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_wdata;
    logic        e_adel;
    logic        e_ades;
    logic [31:0] e_rdout;
  } vec_t;

  vec_t vecs[15];

  // One transaction at minimum latency: addr_ok in the issue cycle, data_ok next.
  task automatic run_vec(input vec_t v, input int idx);
    int hs0;
    string t;
    t = $sformatf("v%0d", idx);
    hs0 = hs_cnt;
    @(negedge clk);
    op = v.op; addr = v.addr; wdata = v.wdata;
    data_addr_ok = 1'b1; data_data_ok = 1'b0; data_rdata = 32'h0;
    #1;
    chk({t, "_req"}, data_req, v.e_req);
    chk({t, "_stall0"}, lsu_stall, v.e_req);
    chk({t, "_adel"}, adel, v.e_adel);
    chk({t, "_ades"}, ades, v.e_ades);
    chk({t, "_badvaddr"}, badvaddr, (v.e_adel | v.e_ades) ? v.addr : 32'h0);
    if (v.e_req) begin
      chk({t, "_wr"}, data_wr, v.e_wr);
      chk({t, "_size"}, data_size, v.e_size);
      chk({t, "_addr"}, data_addr, v.addr);
      chk({t, "_wdata"}, data_wdata, v.e_wdata);
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = v.rdata;
      #1;
      chk({t, "_stall1"}, lsu_stall, 1);
      chk({t, "_req1"}, data_req, 0);
      @(negedge clk);
      data_data_ok = 1'b0; op = OP_NOP;
      #1;
      chk({t, "_stall2"}, lsu_stall, 0);
      chk({t, "_rdata_out"}, rdata_out, v.e_rdout);
    end else begin
      @(negedge clk);
      op = OP_NOP; data_addr_ok = 1'b0;
      #1;
    end
    chk({t, "_handshakes"}, hs_cnt - hs0, v.e_req);
  endtask

  initial begin
    int hs0, rc0;

    //          op      addr          wdata         rdata         req wr sz  e_wdata       adel ades e_rdout
    vecs[0]  = '{OP_LW,  32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 1, 0, 2, 32'h0,         0, 0, 32'hDEAD_BEEF};
    vecs[1]  = '{OP_LB,  32'h0000_1003, 32'h0,        32'h80FF_0000, 1, 0, 0, 32'h0,         0, 0, 32'hFFFF_FF80};
    vecs[2]  = '{OP_LBU, 32'h0000_1003, 32'h0,        32'h80FF_0000, 1, 0, 0, 32'h0,         0, 0, 32'h0000_0080};
    vecs[3]  = '{OP_LH,  32'h0000_1002, 32'h0,        32'h80FF_0000, 1, 0, 1, 32'h0,         0, 0, 32'hFFFF_80FF};
    vecs[4]  = '{OP_LHU, 32'h0000_1002, 32'h0,        32'h80FF_0000, 1, 0, 1, 32'h0,         0, 0, 32'h0000_80FF};
    vecs[5]  = '{OP_SH,  32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 1, 1, 1, 32'hABCD_ABCD, 0, 0, 32'h0000_80FF};
    vecs[6]  = '{OP_SB,  32'h0000_2003, 32'h1234_ABCD, 32'h5555_5555, 1, 1, 0, 32'hCDCD_CDCD, 0, 0, 32'h0000_80FF};
    vecs[7]  = '{OP_SW,  32'h0000_2000, 32'h1234_ABCD, 32'h5555_5555, 1, 1, 2, 32'h1234_ABCD, 0, 0, 32'h0000_80FF};
    vecs[8]  = '{OP_LW,  32'h0000_1001, 32'h0,        32'h0,         0, 0, 0, 32'h0,         1, 0, 32'h0};
    vecs[9]  = '{OP_SH,  32'h0000_2001, 32'h1234_ABCD, 32'h0,         0, 0, 0, 32'h0,         0, 1, 32'h0};
    vecs[10] = '{OP_LB,  32'h0000_1001, 32'h0,        32'h1122_3344, 1, 0, 0, 32'h0,         0, 0, 32'h0000_0033};
    vecs[11] = '{OP_LH,  32'h0000_1000, 32'h0,        32'h7FFF_8344, 1, 0, 1, 32'h0,         0, 0, 32'hFFFF_8344};
    vecs[12] = '{OP_NOP, 32'h0000_1234, 32'hFFFF_FFFF, 32'h0,         0, 0, 0, 32'h0,         0, 0, 32'h0};
    vecs[13] = '{OP_LHU, 32'h0000_1003, 32'h0,        32'h0,         0, 0, 0, 32'h0,         1, 0, 32'h0};
    vecs[14] = '{OP_LW,  32'h0000_2004, 32'h0,        32'hCAFE_F00D, 1, 0, 2, 32'h0,         0, 0, 32'hCAFE_F00D};

    rst = 1'b1; op = OP_NOP; addr = 32'h0; wdata = 32'h0;
    flush = 1'b0; stall_m = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset");

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], i);
    end

    // addr_ok held off for three cycles: request fields must not follow the inputs.
    hs0 = hs_cnt; rc0 = req_cycles;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      op = OP_SW;
      addr = (c == 0) ? 32'h0000_3004 : 32'hFFFF_FFF0;
      wdata = (c == 0) ? 32'hA5A5_A5A5 : 32'h1111_1111;
      data_addr_ok = (c == 3);
      #1;
      chk($sformatf("dly%0d_req", c), data_req, 1);
      chk($sformatf("dly%0d_addr", c), data_addr, 32'h0000_3004);
      chk($sformatf("dly%0d_wdata", c), data_wdata, 32'hA5A5_A5A5);
      chk($sformatf("dly%0d_size", c), data_size, 2);
      chk($sformatf("dly%0d_wr", c), data_wr, 1);
      chk($sformatf("dly%0d_stall", c), lsu_stall, 1);
    end
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
    #1;
    chk("dly_wait_req", data_req, 0);
    chk("dly_wait_stall", lsu_stall, 1);
    @(negedge clk);
    data_data_ok = 1'b0; op = OP_NOP;
    #1;
    chk("dly_done_stall", lsu_stall, 0);
    chk("dly_rdata_out", rdata_out, 32'hCAFE_F00D);
    chk("dly_req_cycles", req_cycles - rc0, 4);
    chk("dly_handshakes", hs_cnt - hs0, 1);

    // Flush while waiting for data: response discarded, block back in IDLE.
    @(negedge clk);
    op = OP_LW; addr = 32'h0000_1000; data_addr_ok = 1'b1;
    #1;
    chk("fwd_req", data_req, 1);
    @(negedge clk);
    data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    chk("fwd_stall_flush", lsu_stall, 1);
    @(negedge clk);
    flush = 1'b0; op = OP_NOP;
    #1;
    chk("fwd_cancel_stall", lsu_stall, 1);
    chk("fwd_cancel_req", data_req, 0);
    @(negedge clk);
    data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    #1;
    chk("fwd_cancel_stall2", lsu_stall, 1);
    @(negedge clk);
    data_data_ok = 1'b0;
    op = OP_LW; addr = 32'h0000_1008; data_addr_ok = 1'b0;
    #1;
    chk("fwd_rdata_kept", rdata_out, 32'hCAFE_F00D);
    chk("fwd_idle_reissue", data_req, 1);
    @(negedge clk);
    data_addr_ok = 1'b1;
    #1;
    chk("fwd_next_req", data_req, 1);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    data_data_ok = 1'b0; op = OP_NOP;
    #1;
    chk("fwd_next_rdata", rdata_out, 32'h0BAD_F00D);

    // Flush while waiting for addr_ok: req stays up, then the response is dropped.
    @(negedge clk);
    op = OP_LW; addr = 32'h0000_100C; data_addr_ok = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fwa_req_flush", data_req, 1);
    @(negedge clk);
    flush = 1'b0; op = OP_NOP; data_addr_ok = 1'b1;
    #1;
    chk("fwa_req_held", data_req, 1);
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    #1;
    chk("fwa_cancel_stall", lsu_stall, 1);
    chk("fwa_cancel_req", data_req, 0);
    @(negedge clk);
    data_data_ok = 1'b0;
    #1;
    chk("fwa_idle_stall", lsu_stall, 0);
    chk("fwa_rdata_kept", rdata_out, 32'h0BAD_F00D);

    // Completion under an external stall: hold DONE, no re-issue.
    hs0 = hs_cnt;
    @(negedge clk);
    op = OP_LW; addr = 32'h0000_1004; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1357_9BDF; stall_m = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      data_data_ok = 1'b0;
      #1;
      chk($sformatf("stm%0d_req", c), data_req, 0);
      chk($sformatf("stm%0d_stall", c), lsu_stall, 0);
      chk($sformatf("stm%0d_rdata", c), rdata_out, 32'h1357_9BDF);
    end
    @(negedge clk);
    stall_m = 1'b0;
    #1;
    chk("stm_release_req", data_req, 0);
    @(negedge clk);
    op = OP_NOP;
    #1;
    chk("stm_handshakes", hs_cnt - hs0, 1);
    chk("stm_rdata_final", rdata_out, 32'h1357_9BDF);

    // Reset in the middle of a transaction.
    @(negedge clk);
    op = OP_LW; addr = 32'h0000_1010; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; op = OP_NOP; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
